mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multi-cycle sequencer for RV32M multiply/divide, attached beside the single-cycle ALU in the execute stage.
- Accepts one operation per start pulse and runs a 32-step shift-add multiply or restoring divide on internal registers.
- Asserts stall to freeze the pipeline until the result is ready, then returns the 32-bit result with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1  in  32  rs1 value; sampled with an accepted start.
- op2  in  32  rs2 value; sampled with an accepted start.
- flush  in  1  abort in-flight operation (branch/trap kill).
- busy  out  1  high in CALC and FIX.
- stall  out  1  combinational: (start & IDLE & !flush) | CALC | FIX.
- done  out  1  one-cycle pulse when result is valid.
- result  out  32  valid while done=1; held until next accepted start.

Behaviour:
- Reset: rst=1 at a rising edge forces state IDLE, counter 0, busy=0, done=0, result=0. Reset overrides start and flush, including mid-CALC.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 & flush=0 latches op and operands.
  - Signed operands (MULH rs1/rs2, MULHSU rs1, DIV/REM both) are converted to magnitude; the result sign is recorded.
  - Next state is CALC with counter=0, or DONE directly for fast paths.
- Fast paths, IDLE->DONE, done at T+1 for a start accepted at edge T:
  - Divide-by-zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC:
  - One iteration per cycle over a 64-bit accumulator.
  - Multiply: if multiplier LSB is set, add the multiplicand to the upper half, then shift right 1.
  - Divide: shift {rem,quot} left 1; trial-subtract the divisor; on non-negative, keep the difference and set quot LSB.
  - After 32 iterations (counter==31) the next state is FIX.
- FIX: applies two's-complement negation if the recorded sign demands it, selects the output word, and moves to DONE.
  - MUL: low 32 bits.
  - MULH, MULHSU, MULHU: high 32 bits.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
- DONE: done=1 for exactly one cycle, result registered, then IDLE.
- Latency: normal op gives done at T+34 (32 CALC + FIX + DONE). stall is low in the DONE cycle so the pipeline advances with the result.
- Back-to-back: start is ignored in CALC, FIX and DONE. A new start is accepted in the first IDLE cycle after DONE.
- flush=1 in CALC or FIX returns to IDLE next cycle with no done pulse; result keeps its previous value. flush in DONE does not suppress done (the result is already committed). flush with start in IDLE suppresses acceptance.
- Arithmetic: all internal adders are 33 bits; operand 0x80000000 magnitude is 0x80000000 unsigned (no overflow).

Optional Feature:
- Macro: MDU_REUSE_EN.
- Defined:
  - Retains the last completed divide's op1, op2, signedness, quotient and remainder.
  - A subsequent DIV/REM (or DIVU/REMU) with identical operands and matching signedness, no intervening flush or rst, goes IDLE->DONE with done at T+1, returning the stored counterpart.
  - The reuse record is invalidated on rst, flush of a divide, or any completed divide with different operands.
- Undefined: no reuse storage; every divide takes the normal or fast path.

Test Plan:
- Reset mid-CALC: start MUL 7*6, assert rst at T+10 -> next cycle IDLE, busy=0, done=0, result=0; no done pulse ever.
- MUL/MULH signed: op1=0xFFFFFFFE (-2), op2=3 -> MUL done at T+34 with 0xFFFFFFFA. Same operands MULH -> 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- Divide signed: DIV op1=-7 (0xFFFFFFF9), op2=2 -> 0xFFFFFFFD (-3). REM same -> 0xFFFFFFFF (-1). stall high T..T+33, low at T+34.
- Fast paths:
  - DIVU 5/0 -> 0xFFFFFFFF at T+1.
  - REM 5/0 -> 5 at T+1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1.
  - REM same operands -> 0 at T+1.
- Flush and back-to-back:
  - Start DIVU 100/7, flush at T+5 -> IDLE at T+6, no done.
  - New DIVU 100/7 at T+7 -> done T+41, result 14.
  - start held high during CALC is ignored.
- MDU_REUSE_EN: DIV 100/7 (done T+34, 14), then REM 100/7 accepted next IDLE cycle -> done one cycle later with 2. Without the macro the same REM takes 34 cycles.

Source files
------------

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/response bundle between the execute stage and the
// multi-cycle RV32M multiply/divide sequencer.
//   start  - request pulse (sampled only while the sequencer is idle)
//   op     - RV32M funct3
//   op1    - rs1 value, op2 - rs2 value
//   flush  - kill an in-flight operation
//   busy   - sequencer in CALC or FIX
//   stall  - freeze the pipeline while the operation is outstanding
//   done   - one-cycle result-valid pulse
//   result - 32-bit result, held until the next accepted start
// master = pipeline side, slave = sequencer side.
interface mdu_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, op1, op2, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, op1, op2, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M multiply/divide sequencer beside the execute ALU.
// One operation per accepted start: 32-step shift-add multiply or restoring
// divide on magnitudes, sign fix-up, then a one-cycle done pulse with result.
// Divide-by-zero and signed overflow complete one cycle after acceptance.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - mdu_seq_if slave: start/op/op1/op2/flush in, busy/stall/done/result out
// Build option:
//   MDU_REUSE_EN - keep the last completed divide's operands, quotient and
//                  remainder; a repeat divide with identical operands and
//                  signedness returns the stored counterpart one cycle later.
module mdu_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic      clk,
  input logic      rst,
  mdu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc_q;      // mul: {product_hi, multiplier}; div: {rem, quot}
  logic [XLEN-1:0]   b_q;        // multiplicand or divisor magnitude
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_quo_q;  // product / quotient sign
  logic              neg_rem_q;  // remainder sign (dividend sign)
  logic [XLEN-1:0]   result_q;

  logic              accept, is_div, s1, s2, a_neg, b_neg;
  logic              dbz, ovf, hit, fast;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res;
  logic [XLEN:0]     sum, diff;
  logic [2*XLEN-1:0] acc_mul, acc_div;
  logic [XLEN-1:0]   hi_fix, quo_fix, rem_fix, fix_res;

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

`ifdef MDU_REUSE_EN
  logic            rv_valid;
  logic [XLEN-1:0] rv_op1, rv_op2, rv_quo, rv_rem;
  logic            rv_uns;
`endif

  // Request decode and fast-path detection
  always_comb begin
    accept = (state_q == IDLE) && bus.start && !bus.flush;
    is_div = bus.op[2];
    s1     = (bus.op == 3'b001) || (bus.op == 3'b010) ||
             (bus.op == 3'b100) || (bus.op == 3'b110);
    s2     = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    a_neg  = s1 && bus.op1[XLEN-1];
    b_neg  = s2 && bus.op2[XLEN-1];
    mag_a  = a_neg ? neg(bus.op1) : bus.op1;
    mag_b  = b_neg ? neg(bus.op2) : bus.op2;
    dbz    = is_div && (bus.op2 == '0);
    ovf    = is_div && !bus.op[0] && (bus.op1 == INT_MIN) && (bus.op2 == '1);
`ifdef MDU_REUSE_EN
    hit    = is_div && rv_valid && (rv_op1 == bus.op1) &&
             (rv_op2 == bus.op2) && (rv_uns == bus.op[0]);
`else
    hit    = 1'b0;
`endif
    fast   = hit || dbz || ovf;

    fast_res = '0;
`ifdef MDU_REUSE_EN
    if (hit)
      fast_res = bus.op[1] ? rv_rem : rv_quo;
    else
`endif
    if (dbz)
      fast_res = bus.op[1] ? bus.op1 : '1;
    else if (ovf)
      fast_res = bus.op[1] ? '0 : INT_MIN;
  end

  // One iteration of each algorithm, plus the sign fix-up
  always_comb begin
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    acc_mul = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    // The shifted partial remainder needs XLEN+1 bits; the top bit of acc_q
    // is folded into the trial subtraction instead of being shifted out.
    diff    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    acc_div = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // High word of a negated 64-bit product: ~hi plus carry out of -lo
    hi_fix  = neg_quo_q ? (~acc_q[2*XLEN-1:XLEN] +
                           {{(XLEN-1){1'b0}}, (acc_q[XLEN-1:0] == '0)})
                        : acc_q[2*XLEN-1:XLEN];
    quo_fix = neg_quo_q ? neg(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix = neg_rem_q ? neg(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    if (op_q[2])
      fix_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q == 3'b000)
      fix_res = acc_q[XLEN-1:0];
    else
      fix_res = hi_fix;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state and outputs
  always_comb begin
    state_d    = state_q;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = fast ? DONE : CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (bus.flush)              state_d = IDLE;
        else if (cnt_q == LAST_CNT) state_d = FIX;
      end
      FIX: begin
        bus.busy = 1'b1;
        state_d  = bus.flush ? IDLE : DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bus.stall  = accept || bus.busy;
    bus.result = result_q;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q      <= bus.op;
            acc_q     <= {{XLEN{1'b0}}, mag_a};
            b_q       <= mag_b;
            cnt_q     <= '0;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (fast) result_q <= fast_res;
          end
        end
        CALC: begin
          if (!bus.flush) begin
            acc_q <= op_q[2] ? acc_div : acc_mul;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          if (!bus.flush) result_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

`ifdef MDU_REUSE_EN
  // Reuse record: cleared on any non-hit divide acceptance and refilled when
  // that divide completes, so a flushed or fast-path divide leaves it empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_valid <= 1'b0;
      rv_op1   <= '0;
      rv_op2   <= '0;
      rv_uns   <= 1'b0;
      rv_quo   <= '0;
      rv_rem   <= '0;
    end else if (accept && is_div && !hit) begin
      rv_valid <= 1'b0;
      rv_op1   <= bus.op1;
      rv_op2   <= bus.op2;
      rv_uns   <= bus.op[0];
    end else if ((state_q == CALC || state_q == FIX) && bus.flush && op_q[2]) begin
      rv_valid <= 1'b0;
    end else if (state_q == FIX && op_q[2]) begin
      rv_valid <= 1'b1;
      rv_quo   <= quo_fix;
      rv_rem   <= rem_fix;
    end
  end
`endif

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq. The driver pushes the expected
// result and latency for each accepted request; an independent monitor pops
// and compares whenever done is seen.
module tb_mdu_seq;

`ifdef MDU_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    int unsigned t;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [31:0] last_res = '0;

  // reference-side reuse record
  bit          rec_v = 1'b0;
  logic [31:0] rec_a = '0;
  logic [31:0] rec_b = '0;
  logic        rec_u = 1'b0;

  mdu_seq_if #(.XLEN(32)) bus ();

  mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // RV32M semantics with plain wide arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb64, ub;
    logic [63:0] ua, ubu, p;
    logic [31:0] r;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub   = {32'b0, b};
    ua   = {32'b0, a};
    ubu  = {32'b0, b};
    p    = '0;
    r    = '0;
    case (op)
      3'd0: begin p = ua * ubu; r = p[31:0]; end
      3'd1: begin p = sa * sb64; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ubu; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF :
                (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a :
                32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a :
                (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 :
                32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done with result %h, expected no done", bus.result);
      end else begin : pop
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("latency", cyc + 1 - e.t, e.lat);
        last_res = e.res;
      end
    end
  end

  // Present a request in the cycle before edge t; t is the acceptance edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit hold,
                          input bit chk_stall, output int unsigned t);
    @(negedge clk);
    bus.op    = op;
    bus.op1   = a;
    bus.op2   = b;
    bus.start = 1'b1;
    t = cyc + 1;
    #1;
    if (chk_stall) chk("stall_at_start", {31'b0, bus.stall}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input bit hold, input bit chk_stall);
    int unsigned t, lat;
    bit hit, fastp, ok;
    exp_t e;
    hit   = op[2] && rec_v && rec_a == a && rec_b == b && rec_u == op[0];
    fastp = op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    if (!op[2])           lat = 34;
    else if (REUSE && hit) lat = 1;
    else if (fastp)       lat = 1;
    else                  lat = 34;
    if (op[2] && !hit) begin
      rec_v = !fastp;
      rec_a = a;
      rec_b = b;
      rec_u = op[0];
    end
    start_op(op, a, b, hold, chk_stall, t);
    e.res = ref_result(op, a, b);
    e.t   = t;
    e.lat = lat;
    sb.push_back(e);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      #1;
      if (chk_stall) chk("stall", {31'b0, bus.stall}, {31'b0, (cyc + 1 < t + lat)});
      if (bus.done === 1'b1) bus.start = 1'b0;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done within 60 cycles, expected done for op %0d", op);
      sb.delete();
      bus.start = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'h80000000;
      2: v = 32'hFFFFFFFF;
      3: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int unsigned t;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op  = '0;
    bus.op1 = '0;
    bus.op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   {31'b0, bus.busy},  32'd0);
    chk("reset_done",   {31'b0, bus.done},  32'd0);
    chk("reset_stall",  {31'b0, bus.stall}, 32'd0);
    chk("reset_result", bus.result,         32'd0);
    rst = 1'b0;

    // reset mid-CALC
    start_op(3'd0, 32'd7, 32'd6, 1'b0, 1'b0, t);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_busy",   {31'b0, bus.busy}, 32'd0);
    chk("midreset_done",   {31'b0, bus.done}, 32'd0);
    chk("midreset_result", bus.result,        32'd0);
    rst = 1'b0;
    rec_v = 1'b0;
    last_res = '0;
    repeat (40) @(negedge clk);

    // directed multiply / divide / fast paths
    run(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    run(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    run(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    run(3'd6, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    run(3'd5, 32'd5, 32'd0, 1'b0, 1'b0);
    run(3'd6, 32'd5, 32'd0, 1'b0, 1'b0);
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    run(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    run(3'd5, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);

    // flush mid-CALC: no done, result held
    start_op(3'd5, 32'd100, 32'd7, 1'b0, 1'b0, t);
    rec_v = 1'b0;
    repeat (6) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy",   {31'b0, bus.busy}, 32'd0);
    chk("flush_result", bus.result,        last_res);

    // flush with start in IDLE suppresses acceptance
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 3'd0;
    #1;
    chk("flush_start_stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_busy", {31'b0, bus.busy}, 32'd0);

    // start held high through CALC is ignored
    run(3'd5, 32'd100, 32'd7, 1'b1, 1'b0);

    // quotient then remainder of the same divide
    run(3'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    run(3'd6, 32'd100, 32'd7, 1'b0, 1'b0);

    // randomized, with frequent repeats of the previous divide's operands
    rop = 3'd4;
    ra  = 32'd1;
    rb  = 32'd1;
    for (int i = 0; i < 60; i++) begin
      if (rop[2] && $urandom_range(0, 2) == 0) begin
        rop = rop ^ 3'b010;
      end else begin
        rop = 3'($urandom_range(0, 7));
        ra  = pick();
        rb  = pick();
      end
      run(rop, ra, rb, 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
